// File: rtl/decode_queue_if.sv
// Fetch/execute handshake bundle for decode_queue: fetch-side inputs, flush,
// execute-side head entry with its decoded fields, and occupancy.
interface decode_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [4:0]      wa;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [CW-1:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, ra1, ra2, wa, imm, illegal, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, ra1, ra2, wa, imm, illegal, count
    );
endinterface

// File: rtl/decode_queue.sv
// Instruction buffer between fetch and execute: DEPTH-entry FIFO whose head is
// presented first-word-fall-through together with its RV64 decode fields.
module decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic           clk,
    input  logic           reset,
    decode_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_OPIMM32= 7'b0011011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_OP32   = 7'b0111011,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;

    logic            w_valid;
    logic            w_ready;
    logic            w_enq;
    logic            w_deq;
    logic [31:0]     w_instr;

    // in_ready follows the async reset pin directly so it drops with it
    assign w_valid = (r_count != '0);
    assign w_ready = (r_count < L_FULL) && !bus.flush && reset;
    assign w_enq   = bus.in_valid && w_ready;
    assign w_deq   = w_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + AW'(1);
            if (w_deq) r_head <= r_head + AW'(1);
            if (w_enq && !w_deq)      r_count <= r_count + (AW + 1)'(1);
            else if (!w_enq && w_deq) r_count <= r_count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc_mem[r_tail]    <= bus.in_pc;
            r_instr_mem[r_tail] <= bus.in_instr;
        end
    end

    assign w_instr       = w_valid ? r_instr_mem[r_head] : '0;
    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_valid ? r_pc_mem[r_head] : '0;
    assign bus.out_instr = w_instr;
    assign bus.count     = r_count;

    always_comb begin
        bus.ra1     = '0;
        bus.ra2     = '0;
        bus.wa      = '0;
        bus.imm     = '0;
        bus.illegal = 1'b0;
        if (w_valid) begin
            case (w_instr[6:0])
                OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: begin
                    bus.ra1 = w_instr[19:15];
                    bus.wa  = w_instr[11:7];
                    bus.imm = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
                end
                OPC_STORE: begin
                    bus.ra1 = w_instr[19:15];
                    bus.ra2 = w_instr[24:20];
                    bus.imm = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                end
                OPC_BRANCH: begin
                    bus.ra1 = w_instr[19:15];
                    bus.ra2 = w_instr[24:20];
                    bus.imm = {{(XLEN-13){w_instr[31]}}, w_instr[31], w_instr[7],
                               w_instr[30:25], w_instr[11:8], 1'b0};
                end
                OPC_OP, OPC_OP32: begin
                    bus.ra1 = w_instr[19:15];
                    bus.ra2 = w_instr[24:20];
                    bus.wa  = w_instr[11:7];
                end
                OPC_LUI, OPC_AUIPC: begin
                    bus.wa  = w_instr[11:7];
                    bus.imm = {{(XLEN-32){w_instr[31]}}, w_instr[31:12], 12'b0};
                end
                OPC_JAL: begin
                    bus.wa  = w_instr[11:7];
                    bus.imm = {{(XLEN-21){w_instr[31]}}, w_instr[31], w_instr[19:12],
                               w_instr[20], w_instr[30:21], 1'b0};
                end
                default: bus.illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Randomized check of decode_queue against a queue-based reference model with
// an arithmetic RV64 immediate/field decoder.
module tb_decode_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 64;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    entry_t q[$];

    decode_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] ins, output logic [4:0] a1,
                                    output logic [4:0] a2, output logic [4:0] w,
                                    output logic [63:0] im, output logic il);
        int s;
        s  = int'(ins) >>> 31;  // 0 or -1: sign of the immediate
        a1 = '0; a2 = '0; w = '0; im = '0; il = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67: begin
                a1 = ins[19:15]; w = ins[11:7];
                im = longint'(int'(ins) >>> 20);
            end
            7'h23: begin
                a1 = ins[19:15]; a2 = ins[24:20];
                im = longint'((int'(ins) >>> 25) * 32 + int'(ins[11:7]));
            end
            7'h63: begin
                a1 = ins[19:15]; a2 = ins[24:20];
                im = longint'(s * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                              + int'(ins[11:8]) * 2);
            end
            7'h33, 7'h3B: begin
                a1 = ins[19:15]; a2 = ins[24:20]; w = ins[11:7];
            end
            7'h37, 7'h17: begin
                w = ins[11:7];
                im = longint'(int'(ins) - int'(ins[11:0]));
            end
            7'h6F: begin
                w = ins[11:7];
                im = longint'(s * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                              + int'(ins[30:21]) * 2);
            end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic check_outputs();
        logic [4:0] a1, a2, w;
        logic [63:0] im;
        logic il;
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH && !bus.flush && rst_n));
        if (q.size() != 0) begin
            ref_dec(q[0].instr, a1, a2, w, im, il);
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_instr", 64'(bus.out_instr), 64'(q[0].instr));
        end else begin
            a1 = '0; a2 = '0; w = '0; im = '0; il = 1'b0;
            chk("out_pc", bus.out_pc, 64'd0);
            chk("out_instr", 64'(bus.out_instr), 64'd0);
        end
        chk("ra1", 64'(bus.ra1), 64'(a1));
        chk("ra2", 64'(bus.ra2), 64'(a2));
        chk("wa", 64'(bus.wa), 64'(w));
        chk("imm", bus.imm, im);
        chk("illegal", 64'(bus.illegal), 64'(il));
    endtask

    // Check at the falling edge, then advance the model across one rising edge.
    task automatic step();
        bit do_enq, do_deq, do_flush;
        entry_t e;
        @(negedge clk);
        check_outputs();
        do_flush = bus.flush;
        do_enq   = bus.in_valid && q.size() < DEPTH && !bus.flush;
        do_deq   = q.size() != 0 && bus.out_ready;
        e.pc     = bus.in_pc;
        e.instr  = bus.in_instr;
        @(posedge clk);
        if (do_flush) q.delete();
        else begin
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] pc, input logic [31:0] ins,
                         input bit ordy, input bit fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h33, 7'h3B,
                7'h37, 7'h17, 7'h6F, 7'h00};
        r = $urandom;
        if ($urandom_range(7) != 0) r[6:0] = ops[$urandom_range(11)];
        return r;
    endfunction

    initial begin
        logic [31:0] sweep [4];
        n_cmp = 0;
        n_err = 0;
        sweep = '{32'h0021A423, 32'h123453B7, 32'hFE000EE3, 32'h00000000};
        rst_n = 1'b0;
        drive(0, '0, '0, 0, 0);
        #3;
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // addi x5,x1,-1
        drive(1, 64'h80000000, 32'hFFF08293, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        #1;
        chk("addi_valid", 64'(bus.out_valid), 64'd1);
        chk("addi_ra1", 64'(bus.ra1), 64'd1);
        chk("addi_wa", 64'(bus.wa), 64'd5);
        chk("addi_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.out_ready = 1'b1;
        step();

        foreach (sweep[i]) begin
            drive(1, 64'h1000 + 64'(4 * i), sweep[i], 0, 0);
            step();
            drive(0, '0, '0, 1, 0);
            step();
        end

        // fill and drain through pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1, 64'h2000 + 64'(4 * i), rand_instr(), 0, 0);
            step();
        end
        chk("full_count", 64'(bus.count), 64'd4);
        drive(1, 64'h2100, rand_instr(), 1, 0);
        step();
        chk("after_deq_count", 64'(bus.count), 64'd3);
        drive(0, '0, '0, 1, 0);
        step();

        // sustained enqueue+dequeue at count 2
        for (int i = 0; i < 10; i++) begin
            drive(1, 64'h3000 + 64'(4 * i), rand_instr(), 1, 0);
            step();
            chk("steady_count", 64'(bus.count), 64'd2);
        end

        // flush at count 3 with in_valid
        drive(1, 64'h4000, rand_instr(), 0, 0);
        step();
        drive(1, 64'h4004, rand_instr(), 0, 1);
        step();
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3) != 0, {$urandom, $urandom}, rand_instr(),
                  $urandom_range(2) != 0, $urandom_range(19) == 0);
            step();
        end

        // async reset with two entries queued
        drive(0, '0, '0, 0, 0);
        step(); step();
        drive(1, 64'h5000, rand_instr(), 0, 0);
        step();
        drive(1, 64'h5004, rand_instr(), 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        chk("pre_reset_count", 64'(bus.count), 64'(q.size()));
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("async_count", 64'(bus.count), 64'd0);
        chk("async_valid", 64'(bus.out_valid), 64'd0);
        chk("async_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 64'h6000, 32'h00A00513, 1, 0);
        step();
        drive(0, '0, '0, 1, 0);
        #1;
        chk("post_reset_pc", bus.out_pc, 64'h6000);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage with an instruction buffer between fetch and execute. Fetched (pc, instruction) pairs are held in a DEPTH-entry FIFO with valid/ready handshakes on both sides. The entry at the head is decoded into register-read addresses, destination address, a sign-extended immediate and an illegal flag. Unlike the earlier purely combinational decode, it buffers fetch bursts, absorbs execute back-pressure and supports a single-cycle flush on redirect.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- XLEN, 64: width of pc and immediate.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept an instruction.
- in_pc  in  XLEN  pc of the fetched instruction.
- in_instr  in  32  raw instruction.
- flush  in  1  discard all buffered entries (branch/exception redirect).
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  execute consumes the head this cycle.
- out_pc  out  XLEN  pc of the head entry.
- out_instr  out  32  raw instruction of the head entry.
- ra1  out  5  rs1 address, or 0 if the instruction does not use rs1.
- ra2  out  5  rs2 address, or 0 if the instruction does not use rs2.
- wa  out  5  rd address, or 0 if the instruction does not write rd.
- imm  out  XLEN  sign-extended immediate.
- illegal  out  1  the head opcode is not recognised.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits; pointers wrap naturally; count tracked separately.
- Enqueue when in_valid && in_ready: write {in_pc, in_instr} at tail, tail+1.
- in_ready = (count < DEPTH) && !flush && reset deasserted. It does not depend on out_ready, so a full buffer refuses input even on a dequeue cycle.
- Dequeue when out_valid && out_ready: head+1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- out_valid = (count != 0). The head is presented first-word-fall-through: out_pc, out_instr and the decode fields are combinational from the head entry.
- Flush has priority over everything. On the next edge head = tail = count = 0. An enqueue or dequeue in the flush cycle has no effect.
- Decode classes by opcode [6:0]:
  - LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111: I-type. ra1 and wa used; imm = sext(instr[31:20]).
  - STORE 0100011: S-type. ra1 and ra2 used; imm = sext({[31:25],[11:7]}).
  - BRANCH 1100011: B-type. ra1 and ra2 used; imm = sext({[31],[7],[30:25],[11:8],0}).
  - OP 0110011, OP-32 0111011: R-type. ra1, ra2 and wa used; imm = 0.
  - LUI 0110111, AUIPC 0010111: U-type. wa used; imm = sext({[31:12],12'b0}).
  - JAL 1101111: J-type. wa used; imm = sext({[31],[19:12],[20],[30:21],0}).
  - Any other opcode: illegal = 1; ra1, ra2, wa and imm all 0.
- Unused register fields are 0. Sign extension is from the top immediate bit to XLEN.
- When out_valid = 0, all decode outputs, out_pc and out_instr are 0 and illegal is 0.

## Timing
- Reset (async assert) clears head, tail and count to 0. Outputs during and after reset: out_valid 0, in_ready 0 while asserted and 1 after deassertion, count 0, all data outputs 0. Storage contents are not reset.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: an instruction enqueued at edge N appears at the outputs with out_valid = 1 after edge N; it can be consumed in the cycle after N. There is no same-cycle bypass from input to output.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- Flush asserted in cycle N: in_ready is 0 in cycle N, and out_valid is 0 after edge N.
- count is registered and reflects all completed edges.

## Test plan
- Reset, then enqueue 0xFFF08293 (addi x5,x1,-1) at pc 0x80000000 -> next cycle: out_valid 1, ra1 1, ra2 0, wa 5, imm 0xFFFFFFFFFFFFFFFF, illegal 0, count 1.
- Decode sweep: 0x0021A423 (sw x2,8(x3)) -> ra1 3, ra2 2, wa 0, imm 8. 0x123453B7 (lui x7) -> wa 7, imm 0x12345000. 0xFE000EE3 (beq x0,x0,-4) -> imm 0xFFFFFFFFFFFFFFFC. 0x00000000 -> illegal 1, all fields 0.
- Fill with DEPTH=4, out_ready held 0: after 4 enqueues, in_ready 0 and count 4. Assert out_ready for one cycle -> the first pc is dequeued, count 3, in_ready 1. Entries come out in FIFO order across pointer wrap.
- Simultaneous enqueue and dequeue at count 2 for 10 cycles -> count stays 2, pcs are output in order, no losses.
- Flush at count 3 together with in_valid -> after the edge: count 0, out_valid 0, and the flush-cycle instruction is never output.
- Assert reset between edges with count 2 -> out_valid 0 and count 0 immediately; after release, the first new enqueue is the first instruction output.
